riscv_atomic_responder: RTL
===========================

# riscv_atomic_responder

Responder end of the inter-core atomic protocol. Accepts `atomic_req_t` requests from any hart, performs the read-modify-write against a shared memory port, and returns an `atomic_rsp_t` response. Maintains the LR/SC reservation set for all harts. Sits between the inter-core fabric and the shared L2/memory interface.

## Interface
Parameters:
- `NUM_HARTS`, default 4: number of reservation entries; hart IDs ≥ `NUM_HARTS` get an error response.
- `HART_ID_WIDTH`, `ADDR_WIDTH`, `XLEN`: from `riscv_config_pkg`.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_i`  in  `atomic_req_t`  request; `req_i.valid` qualifies it
- `req_ready_o`  out  1  request accepted when `req_i.valid && req_ready_o`
- `rsp_o`  out  `atomic_rsp_t`  response; `rsp_o.valid` qualifies it
- `rsp_ready_i`  in  1  response consumed when `rsp_o.valid && rsp_ready_i`
- `mem_req_o`  out  1  memory request, held until granted
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_addr_o`  out  `ADDR_WIDTH`  word address
- `mem_wdata_o`  out  `XLEN`  write data
- `mem_gnt_i`  in  1  request accepted this cycle
- `mem_rvalid_i`  in  1  read data or write acknowledge valid
- `mem_rdata_i`  in  `XLEN`  read data
- `mem_err_i`  in  1  bus error, sampled with `mem_rvalid_i`

## Operation
States and transitions:
- IDLE: `req_ready_o`=1. On accept, latch the request. A misaligned address (`addr[1:0]`≠0), an op code above SC, or an out-of-range hart goes to RSP with error. SC goes to WR_REQ if its reservation hits, otherwise to RSP. Every other op goes to RD_REQ.
- RD_REQ: `mem_req_o`=1, `mem_we_o`=0. Go to RD_WAIT on `mem_gnt_i`.
- RD_WAIT: on `mem_rvalid_i`, latch old = `mem_rdata_i`, compute new, then:
  - `mem_err_i` → RSP with error.
  - LR → RSP.
  - CAS with old≠compare_data → RSP.
  - otherwise → WR_REQ.
- WR_REQ: `mem_req_o`=1, `mem_we_o`=1, `mem_wdata_o`=new. Go to WR_WAIT on `mem_gnt_i`.
- WR_WAIT: on `mem_rvalid_i` go to RSP. `mem_err_i` sets error.
- RSP: `rsp_o.valid`=1 and all fields stable. Go to IDLE on `rsp_ready_i`.

Per-op arithmetic (XLEN bits, wrap-around on overflow; `data` is the request operand):
- ADD: old+data.
- AND/OR/XOR: bitwise.
- MIN/MAX: signed compare.
- MINU/MAXU: unsigned compare.
- SWAP: data.
- CAS: write data only if old==compare_data.

Response fields:
- `tag`: echoed from the request.
- `old_data`: value read from memory. SC has no read: `old_data`=0 on success, 1 on failure.
- `new_data`: value written. If nothing was written, `new_data`=`old_data`.
- `success`: 1 for completed AMOs, LR, a matching CAS and a successful SC; 0 on failure or error.
- `error`: 1 for invalid requests and bus errors.

Reservations (one valid bit plus word address per hart):
- LR sets the requesting hart's entry.
- SC hits only if that entry is valid and its address equals the request address. Every SC clears the requester's entry, hit or miss.
- A successful write clears every entry whose address matches the written word, including other harts' entries.
- Error paths leave reservations unchanged.

## Timing
- Reset values:
  - state IDLE, `req_ready_o`=1.
  - `rsp_o` all-zero.
  - `mem_req_o`/`mem_we_o`=0, `mem_addr_o`/`mem_wdata_o`=0.
  - all reservations invalid.
- Reset asserted mid-transaction aborts immediately. No response is issued and `mem_req_o` drops asynchronously.
- One transaction in flight. `req_ready_o`=0 outside IDLE.
- Minimum latency for an RMW, with `mem_gnt_i` in the request cycle and `mem_rvalid_i` one cycle later: accept at cycle 0, `rsp_o.valid` at cycle 5.
- Error-at-accept latency: `rsp_o.valid` at cycle 1.
- SC latency when `mem_rvalid_i` follows `mem_gnt_i` by one cycle: success at cycle 3; failure at cycle 1.
- `mem_addr_o`, `mem_we_o` and `mem_wdata_o` are stable while `mem_req_o`=1 and not granted.
- `mem_rvalid_i` outside RD_WAIT/WR_WAIT is ignored.
- `rsp_ready_i` is allowed high before valid. Back-to-back throughput: a new accept at the earliest one cycle after the RSP handshake.

## Test plan
- ADD: mem[0x100]=0xFFFF_FFFF, ADD data=2, tag=0x5A → old=0xFFFF_FFFF, new=0x0000_0001, mem=1, success=1, tag=0x5A.
- MIN vs MINU: mem=0x8000_0000, data=1. MIN → new=0x8000_0000, no value change. MINU → new=1.
- CAS: mem=7, compare=7, data=9 → success=1, mem=9. Repeat with compare=7 → success=0, no write cycle, new=old=9.
- LR/SC across harts:
  - hart0 LR 0x200, hart1 SWAP 0x200, hart0 SC → success=0, old_data=1, no memory access.
  - Repeat without the SWAP → success=1, old_data=0.
- Errors:
  - addr 0x102 → error=1 at cycle 1, no `mem_req_o`.
  - `mem_err_i` on read → error=1, no write, reservations unchanged.
- Stalls and reset:
  - hold `mem_gnt_i`=0 for 10 cycles → request stable.
  - hold `rsp_ready_i`=0 → response stable.
  - assert `rst_ni` in WR_REQ → all outputs at reset values, reservations cleared.

Source files
------------

// File: rtl/riscv_atomic_responder.sv
// Responder for inter-core atomics: AMO/LR/SC read-modify-write on a shared memory port, plus reservations.
// Latency: RMW >= 5 cycles, SC 3 (hit) / 1 (miss), invalid request 1; one transaction in flight.
// Backpressure: req_ready_o only in IDLE; mem request held until granted, response held until consumed.
package riscv_config_pkg;
    localparam int HART_ID_WIDTH = 4;
    localparam int ADDR_WIDTH    = 32;
    localparam int XLEN          = 32;
    localparam int TAG_WIDTH     = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_MIN  = 4'd4;
    localparam logic [3:0] OP_MAX  = 4'd5;
    localparam logic [3:0] OP_MINU = 4'd6;
    localparam logic [3:0] OP_MAXU = 4'd7;
    localparam logic [3:0] OP_SWAP = 4'd8;
    localparam logic [3:0] OP_CAS  = 4'd9;
    localparam logic [3:0] OP_LR   = 4'd10;
    localparam logic [3:0] OP_SC   = 4'd11;

    typedef struct packed {
        logic                     valid;
        logic [HART_ID_WIDTH-1:0] hart_id;
        logic [TAG_WIDTH-1:0]     tag;
        logic [3:0]               op;
        logic [ADDR_WIDTH-1:0]    addr;
        logic [XLEN-1:0]          data;
        logic [XLEN-1:0]          compare_data;
    } atomic_req_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      old_data;
        logic [XLEN-1:0]      new_data;
        logic                 success;
        logic                 error;
    } atomic_rsp_t;
endpackage

module riscv_atomic_responder
    import riscv_config_pkg::*;
#(
    parameter int NUM_HARTS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  atomic_req_t           req_i,
    output logic                  req_ready_o,
    output atomic_rsp_t           rsp_o,
    input  logic                  rsp_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  mem_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RSP
    } state_t;

    state_t state_q, state_d;

    logic [HART_ID_WIDTH-1:0] hart_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic [3:0]               op_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [XLEN-1:0]          data_q;
    logic [XLEN-1:0]          cmp_q;
    logic [XLEN-1:0]          old_q;
    logic [XLEN-1:0]          new_q;
    logic                     success_q;
    logic                     error_q;

    logic [NUM_HARTS-1:0]     rsv_vld;
    logic [ADDR_WIDTH-1:0]    rsv_addr [NUM_HARTS];

    logic                     bad_req;
    logic                     sc_hit;
    logic                     cas_match;
    logic [XLEN-1:0]          amo_result;

    always_comb begin
        bad_req = (req_i.addr[1:0] != 2'b00) || (req_i.op > OP_SC) ||
                  (int'(req_i.hart_id) >= NUM_HARTS);
        sc_hit  = 1'b0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (int'(req_i.hart_id) == h && rsv_vld[h] && rsv_addr[h] == req_i.addr)
                sc_hit = 1'b1;
        end
    end

    assign cas_match = (mem_rdata_i == cmp_q);

    // SWAP and CAS both write the operand; CAS is gated by cas_match in the FSM
    always_comb begin
        amo_result = data_q;
        case (op_q)
            OP_ADD:  amo_result = mem_rdata_i + data_q;
            OP_AND:  amo_result = mem_rdata_i & data_q;
            OP_OR:   amo_result = mem_rdata_i | data_q;
            OP_XOR:  amo_result = mem_rdata_i ^ data_q;
            OP_MIN:  amo_result = ($signed(mem_rdata_i) < $signed(data_q)) ? mem_rdata_i : data_q;
            OP_MAX:  amo_result = ($signed(mem_rdata_i) > $signed(data_q)) ? mem_rdata_i : data_q;
            OP_MINU: amo_result = (mem_rdata_i < data_q) ? mem_rdata_i : data_q;
            OP_MAXU: amo_result = (mem_rdata_i > data_q) ? mem_rdata_i : data_q;
            default: amo_result = data_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i.valid) begin
                    if (bad_req)                state_d = S_RSP;
                    else if (req_i.op == OP_SC) state_d = sc_hit ? S_WR_REQ : S_RSP;
                    else                        state_d = S_RD_REQ;
                end
            end
            S_RD_REQ:  if (mem_gnt_i) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i || op_q == OP_LR || (op_q == OP_CAS && !cas_match))
                        state_d = S_RSP;
                    else
                        state_d = S_WR_REQ;
                end
            end
            S_WR_REQ:  if (mem_gnt_i) state_d = S_WR_WAIT;
            S_WR_WAIT: if (mem_rvalid_i) state_d = S_RSP;
            S_RSP:     if (rsp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hart_q    <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cmp_q     <= '0;
            old_q     <= '0;
            new_q     <= '0;
            success_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i.valid) begin
                        hart_q    <= req_i.hart_id;
                        tag_q     <= req_i.tag;
                        op_q      <= req_i.op;
                        addr_q    <= req_i.addr;
                        data_q    <= req_i.data;
                        cmp_q     <= req_i.compare_data;
                        old_q     <= '0;
                        new_q     <= '0;
                        success_q <= 1'b0;
                        error_q   <= 1'b0;
                        if (bad_req) begin
                            error_q <= 1'b1;
                        end else if (req_i.op == OP_SC) begin
                            // SC reports 0 in old_data on success and 1 on failure
                            if (sc_hit) begin
                                new_q     <= req_i.data;
                                success_q <= 1'b1;
                            end else begin
                                old_q <= XLEN'(1);
                                new_q <= XLEN'(1);
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        old_q <= mem_rdata_i;
                        new_q <= mem_rdata_i;
                        if (mem_err_i) begin
                            error_q <= 1'b1;
                        end else if (op_q == OP_LR) begin
                            success_q <= 1'b1;
                        end else if (!(op_q == OP_CAS && !cas_match)) begin
                            new_q     <= amo_result;
                            success_q <= 1'b1;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (mem_rvalid_i && mem_err_i) begin
                        error_q   <= 1'b1;
                        success_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A hitting SC loses its reservation through the address-match clear on write completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsv_vld <= '0;
            for (int h = 0; h < NUM_HARTS; h++) rsv_addr[h] <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (state_q == S_IDLE && req_i.valid && !bad_req && req_i.op == OP_SC &&
                    !sc_hit && int'(req_i.hart_id) == h)
                    rsv_vld[h] <= 1'b0;
                if (state_q == S_RD_WAIT && mem_rvalid_i && !mem_err_i && op_q == OP_LR &&
                    int'(hart_q) == h) begin
                    rsv_vld[h]  <= 1'b1;
                    rsv_addr[h] <= addr_q;
                end
                if (state_q == S_WR_WAIT && mem_rvalid_i && !mem_err_i && rsv_addr[h] == addr_q)
                    rsv_vld[h] <= 1'b0;
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign mem_we_o    = (state_q == S_WR_REQ);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = new_q;

    always_comb begin
        rsp_o          = '0;
        rsp_o.valid    = (state_q == S_RSP);
        rsp_o.tag      = tag_q;
        rsp_o.old_data = old_q;
        rsp_o.new_data = new_q;
        rsp_o.success  = success_q;
        rsp_o.error    = error_q;
    end

endmodule
